// File: rtl/trigger_sequencer_pkg.sv
// Shared types and constants for the comparator trigger sequencer and its receiver.
package trigger_sequencer_pkg;

    localparam int unsigned CntW           = 16;
    // Shortest t_reset pulse the trigger receiver can reliably detect.
    localparam int unsigned MinResetCycles = 2;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StRstPulse = 3'd1,
        StSettle   = 3'd2,
        StArmed    = 3'd3,
        StCapture  = 3'd4,
        StDone     = 3'd5
    } seq_state_e;

endpackage

// File: rtl/trigger_sequencer_down_counter.sv
// seq_down_counter: loadable down-counter that saturates at zero and flags it.
module seq_down_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/trigger_sequencer.sv
// Acquisition sequencer on the initiator side of the comparator trigger interface.
// Optional forced trigger after an armed timeout: TRIGGER_SEQUENCER_AUTO_TRIGGER_EN.
module trigger_sequencer
    import trigger_sequencer_pkg::*;
#(
    parameter int unsigned RESET_CYCLES      = 4,
    parameter int unsigned SETTLE_CYCLES     = 8,
    parameter int unsigned POST_TRIG_SAMPLES = 1024,
    parameter int unsigned CNT_W             = CntW,
    parameter int unsigned AUTO_TIMEOUT      = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic arm_req,
    input  logic abort,
    input  logic triggered,
    output logic t_reset,
    output logic armed,
    output logic capture_active,
    output logic trig_seen,
    output logic capture_done,
    output logic busy,
    output logic auto_trig
);

    if (RESET_CYCLES < MinResetCycles || RESET_CYCLES >= 2 ** CNT_W) begin : g_bad_reset
        $error("RESET_CYCLES out of range");
    end
    if (SETTLE_CYCLES >= 2 ** CNT_W) begin : g_bad_settle
        $error("SETTLE_CYCLES out of range");
    end
    if (POST_TRIG_SAMPLES < 1 || POST_TRIG_SAMPLES >= 2 ** CNT_W) begin : g_bad_post
        $error("POST_TRIG_SAMPLES out of range");
    end
    if (AUTO_TIMEOUT < 1 || AUTO_TIMEOUT >= 2 ** CNT_W) begin : g_bad_timeout
        $error("AUTO_TIMEOUT out of range");
    end

    localparam logic [CNT_W-1:0] ResetLoad  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SettleLoad =
        (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PostLoad   = CNT_W'(POST_TRIG_SAMPLES - 1);

    seq_state_e       state_q, state_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;
    logic             trig_accept;
    logic             t_reset_q, armed_q, capture_active_q, trig_seen_q, capture_done_q, busy_q;

    seq_down_counter #(.W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (1'b1),
        .zero     (cnt_zero)
    );

`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
    logic timeout_zero;
    logic auto_fire;
    logic auto_trig_q;

    seq_down_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     ((state_q != StArmed) && (state_d == StArmed)),
        .load_val (CNT_W'(AUTO_TIMEOUT - 1)),
        .en       (state_q == StArmed),
        .zero     (timeout_zero)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        trig_accept  = 1'b0;
`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
        auto_fire    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (arm_req) begin
                    state_d      = StRstPulse;
                    cnt_load     = 1'b1;
                    cnt_load_val = ResetLoad;
                end
            end
            StRstPulse: begin
                if (cnt_zero) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = StArmed;
                    end else begin
                        state_d      = StSettle;
                        cnt_load     = 1'b1;
                        cnt_load_val = SettleLoad;
                    end
                end
            end
            StSettle: begin
                if (cnt_zero) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (triggered) begin
                    state_d      = StCapture;
                    cnt_load     = 1'b1;
                    cnt_load_val = PostLoad;
                    trig_accept  = 1'b1;
                end
`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
                else if (timeout_zero) begin
                    state_d      = StCapture;
                    cnt_load     = 1'b1;
                    cnt_load_val = PostLoad;
                    trig_accept  = 1'b1;
                    auto_fire    = 1'b1;
                end
`endif
            end
            StCapture: begin
                if (cnt_zero) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides any transition; in IDLE it also blocks a same-cycle arm.
        if (abort) begin
            state_d     = StIdle;
            cnt_load    = 1'b0;
            trig_accept = 1'b0;
`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
            auto_fire   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_reset_q        <= 1'b0;
            armed_q          <= 1'b0;
            capture_active_q <= 1'b0;
            trig_seen_q      <= 1'b0;
            capture_done_q   <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            t_reset_q        <= (state_d == StRstPulse);
            armed_q          <= (state_d == StArmed);
            capture_active_q <= (state_d == StCapture);
            trig_seen_q      <= trig_accept;
            capture_done_q   <= (state_d == StDone);
            busy_q           <= (state_d != StIdle);
        end
    end

`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_trig_q <= 1'b0;
        end else if ((state_q == StIdle) && (state_d == StRstPulse)) begin
            auto_trig_q <= 1'b0;
        end else if (auto_fire) begin
            auto_trig_q <= 1'b1;
        end
    end

    assign auto_trig = auto_trig_q;
`else
    assign auto_trig = 1'b0;
`endif

    assign t_reset        = t_reset_q;
    assign armed          = armed_q;
    assign capture_active = capture_active_q;
    assign trig_seen      = trig_seen_q;
    assign capture_done   = capture_done_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer; output vector order is
// {t_reset, armed, capture_active, trig_seen, capture_done, busy, auto_trig}.
module tb_trigger_sequencer;

    logic clk = 1'b0;
    logic rst, arm_req, abort, triggered;
    logic t_reset, armed, capture_active, trig_seen, capture_done, busy, auto_trig;

    int checks = 0;
    int errors = 0;

    trigger_sequencer #(
        .RESET_CYCLES      (4),
        .SETTLE_CYCLES     (8),
        .POST_TRIG_SAMPLES (16),
        .CNT_W             (16),
        .AUTO_TIMEOUT      (100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm_req        (arm_req),
        .abort          (abort),
        .triggered      (triggered),
        .t_reset        (t_reset),
        .armed          (armed),
        .capture_active (capture_active),
        .trig_seen      (trig_seen),
        .capture_done   (capture_done),
        .busy           (busy),
        .auto_trig      (auto_trig)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] outs();
        return {t_reset, armed, capture_active, trig_seen, capture_done, busy, auto_trig};
    endfunction

    function automatic logic in_rng(input int c, input int lo, input int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        arm_req   = 1'b0;
        abort     = 1'b0;
        triggered = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm_req = 1'b1; abort = 1'b0; triggered = 1'b1;
        tick();
        tick();
        checks++;
        if (outs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold: outputs %b, required %b", outs(), 7'b0);
        end
        arm_req = 1'b0; triggered = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (outs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_release: outputs %b, required %b", outs(), 7'b0);
        end
    endtask

    task automatic test_nominal();
        logic [6:0] exp;
        do_reset();
        for (int c = 1; c <= 50; c++) begin
            tick();
            exp = {in_rng(c, 11, 14), in_rng(c, 23, 30), in_rng(c, 31, 46), c == 31, c == 47,
                   in_rng(c, 11, 47), 1'b0};
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL nominal cycle %0d: outputs %b, required %b", c, outs(), exp);
            end
            arm_req   = (c == 10);
            triggered = (c == 30);
        end
    endtask

    task automatic test_early_trigger();
        logic [6:0] exp;
        do_reset();
        for (int c = 1; c <= 36; c++) begin
            tick();
            exp = {in_rng(c, 3, 6), c == 15, in_rng(c, 16, 31), c == 16, c == 32,
                   in_rng(c, 3, 32), 1'b0};
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL early_trigger cycle %0d: outputs %b, required %b", c, outs(), exp);
            end
            arm_req   = (c == 2);
            triggered = (c >= 8);
        end
        triggered = 1'b0;
    endtask

    task automatic abort_case(input int ab, input bit trig);
        logic [6:0] exp;
        int armed_end;
        armed_end = trig ? 15 : 1000;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            tick();
            exp = {in_rng(c, 3, 6), in_rng(c, 15, armed_end), trig && in_rng(c, 16, 31),
                   trig && (c == 16), c == 32, in_rng(c, 3, 32), 1'b0};
            if (c > ab) exp = '0;
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL abort_at_%0d cycle %0d: outputs %b, required %b",
                         ab, c, outs(), exp);
            end
            arm_req   = (c == 2);
            triggered = trig && (c == 15);
            abort     = (c == ab);
        end
    endtask

    task automatic test_abort();
        abort_case(4, 1'b0);
        abort_case(16, 1'b0);
        abort_case(20, 1'b1);
        // arm_req and abort together in IDLE: abort wins
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (outs() !== 7'b0) begin
                errors++;
                $display("FAIL arm_abort_idle cycle %0d: outputs %b, required %b",
                         c, outs(), 7'b0);
            end
            arm_req = (c == 2);
            abort   = (c == 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            tick();
            exp = {in_rng(c, 3, 6) || in_rng(c, 34, 37), c == 15, in_rng(c, 16, 31), c == 16,
                   c == 32, in_rng(c, 3, 32) || (c >= 34), 1'b0};
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL rearm cycle %0d: outputs %b, required %b", c, outs(), exp);
            end
            arm_req   = (c == 2) || (c == 20) || (c == 33);
            triggered = (c == 15);
        end
    endtask

    task automatic test_simultaneity();
        logic [6:0] exp;
        do_reset();
        for (int c = 1; c <= 25; c++) begin
            tick();
            exp = {in_rng(c, 3, 6), in_rng(c, 15, 17), 1'b0, 1'b0, 1'b0, in_rng(c, 3, 17), 1'b0};
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL abort_vs_trigger cycle %0d: outputs %b, required %b",
                         c, outs(), exp);
            end
            arm_req   = (c == 2);
            abort     = (c == 17);
            triggered = (c == 17);
        end
        do_reset();
        for (int c = 1; c <= 30; c++) begin
            tick();
            exp = {in_rng(c, 3, 6), c == 15, in_rng(c, 16, 20), c == 16, 1'b0,
                   in_rng(c, 3, 20), 1'b0};
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL rst_mid_capture cycle %0d: outputs %b, required %b",
                         c, outs(), exp);
            end
            arm_req   = (c == 2);
            triggered = (c == 15);
            rst       = (c == 20);
        end
    endtask

`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
    task automatic test_auto_trigger();
        logic [6:0] exp;
        for (int run = 0; run < 2; run++) begin
            do_reset();
            for (int c = 1; c <= 140; c++) begin
                tick();
                exp = {in_rng(c, 3, 6), in_rng(c, 15, 114), in_rng(c, 115, 130), c == 115,
                       c == 131, in_rng(c, 3, 131), (run == 0) && (c >= 115)};
                checks++;
                if (outs() !== exp) begin
                    errors++;
                    $display("FAIL auto_trigger run %0d cycle %0d: outputs %b, required %b",
                             run, c, outs(), exp);
                end
                arm_req   = (c == 2);
                triggered = (run == 1) && (c == 114);
            end
        end
        // A fresh arm clears the sticky flag.
        arm_req = 1'b1;
        tick();
        arm_req = 1'b0;
        do_reset();
    endtask
`endif

    initial begin
        rst = 1'b1; arm_req = 1'b0; abort = 1'b0; triggered = 1'b0;
        test_reset();
        test_nominal();
        test_early_trigger();
        test_abort();
        test_back_to_back();
        test_simultaneity();
`ifdef TRIGGER_SEQUENCER_AUTO_TRIGGER_EN
        test_auto_trigger();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Initiator side of the comparator trigger interface.
- Drives `armed` and `t_reset` into the trigger receiver and consumes its synchronized `triggered` level.
- Sequences one acquisition: comparator reset pulse, settle window, armed wait, post-trigger sample count, then a completion pulse.
- Sits between the host command decoder (arm/abort) and the capture/readout logic.

Parameters:
- RESET_CYCLES, 4, width of the `t_reset` pulse in clk cycles (>=2, so the receiver sees a clean rising edge).
- SETTLE_CYCLES, 8, cycles after `t_reset` deasserts before arming (comparator latch recovery).
- POST_TRIG_SAMPLES, 1024, capture cycles counted after the trigger is accepted (>=1).
- CNT_W, 16, shared counter width; must satisfy 2^CNT_W > max of all cycle parameters.
- AUTO_TIMEOUT, 65535, armed-wait cycles before a forced trigger (used only with AUTO_TRIGGER_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- arm_req  in  1  single-cycle request to start an acquisition.
- abort  in  1  single-cycle request to cancel the current acquisition.
- triggered  in  1  synchronized trigger level from the trigger receiver.
- t_reset  out  1  comparator reset request to the trigger receiver; also clears its `triggered`.
- armed  out  1  enables trigger latching in the receiver.
- capture_active  out  1  high for exactly POST_TRIG_SAMPLES cycles after trigger acceptance.
- trig_seen  out  1  one-cycle pulse on trigger acceptance.
- capture_done  out  1  one-cycle pulse at acquisition end.
- busy  out  1  high in every state except IDLE.
- auto_trig  out  1  sticky flag: last trigger was forced (tied 0 without the macro).

Behaviour:
- Reset: all outputs 0; state = IDLE; counter = 0. A reset mid-operation returns to IDLE on the next edge with no `capture_done` pulse.
- All outputs are registered (Moore); no combinational path from inputs to outputs.
- Shared down-counter `cnt` (CNT_W bits), loaded on each state entry.
- IDLE: `arm_req`=1 -> RST_PULSE, cnt=RESET_CYCLES-1, `t_reset`=1 from the next cycle; `auto_trig` cleared.
- RST_PULSE: `t_reset`=1, `armed`=0. cnt==0 -> SETTLE, cnt=SETTLE_CYCLES-1. `t_reset` is high exactly RESET_CYCLES cycles.
- SETTLE: `t_reset`=0, `armed`=0; `triggered` ignored. cnt==0 -> ARMED. If SETTLE_CYCLES=0, go straight from RST_PULSE to ARMED.
- ARMED: `armed`=1. `triggered`=1 sampled -> CAPTURE, cnt=POST_TRIG_SAMPLES-1, `trig_seen` pulses that same transition cycle, `armed` drops to 0 on entry to CAPTURE.
- CAPTURE: `capture_active`=1. cnt==0 -> DONE.
- DONE: `capture_done`=1 for one cycle -> IDLE.
- `arm_req` in any non-IDLE state: ignored, not queued.
- `abort` (non-IDLE): -> IDLE next cycle; `armed`, `t_reset` and `capture_active` low, no `capture_done`. `abort` takes priority over a simultaneous `triggered` or counter expiry. `abort` in IDLE is a no-op.
- `arm_req` and `abort` together in IDLE: `abort` wins; stay IDLE.
- No wrap-around: the counter only decrements while its state is active and reloads on every state entry.

Optional Feature:
- Macro: TRIGGER_SEQUENCER_AUTO_TRIGGER_EN.
- Defined: a second counter runs in ARMED. After AUTO_TIMEOUT cycles without `triggered`, the block enters CAPTURE exactly as on a real trigger (`trig_seen` pulses) and sets `auto_trig`=1 until the next accepted `arm_req` or rst. A real trigger in the same cycle as the timeout wins, with `auto_trig`=0.
- Undefined: ARMED waits indefinitely; `auto_trig` tied 0; no timeout counter is synthesized.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE, RST_PULSE, SETTLE, ARMED, CAPTURE, DONE; 3 bits);
  - CNT_W default;
  - the minimum-reset-width constant also used by the trigger receiver.
- One natural sub-module: `seq_down_counter` (load/enable/zero-flag down-counter), instantiated once for the phase counter and once more for the auto-trigger timeout.

Test Plan:
- Nominal (RESET_CYCLES=4, SETTLE_CYCLES=8, POST_TRIG_SAMPLES=16):
  - `arm_req` at cycle 10 -> `t_reset` high cycles 11-14, `armed` high from cycle 23.
  - `triggered` at cycle 30 -> `trig_seen` at 31, `capture_active` cycles 31-46, `capture_done` at 47, `busy` low at 48.
- Early trigger: `triggered` held 1 during SETTLE -> ignored; accepted on the first ARMED cycle.
- Abort in each of RST_PULSE, ARMED and CAPTURE -> IDLE next cycle, `capture_done` never pulses, all drive outputs 0.
- Re-arm: `arm_req` during CAPTURE -> ignored; `arm_req` one cycle after `capture_done` -> a new `t_reset` pulse of exactly 4 cycles.
- Simultaneity:
  - `abort` and `triggered` in the same ARMED cycle -> IDLE, no `trig_seen`.
  - rst asserted mid-CAPTURE -> all outputs 0 on the next edge.
- With macro, AUTO_TIMEOUT=100:
  - no trigger -> CAPTURE entered 100 cycles after `armed` rises, `auto_trig`=1.
  - repeat with `triggered` on the timeout cycle -> `auto_trig`=0.
